// File: rtl/noc_decoder_pkg.sv
// Shared types and flit helpers for the N-way wormhole decoder.
package noc_decoder_pkg;

   localparam int unsigned DROP_CNT_W = 16;
   localparam int unsigned MAX_W      = 64;
   localparam int unsigned MAX_A      = 16;
   localparam int unsigned MAX_P      = 5;

   typedef enum logic [1:0] {HEAD, BODY, DROP} state_e;

   typedef struct packed {
      logic             drop;
      logic [MAX_P-1:0] port;
   } route_t;

   function automatic logic flit_tail(input logic [MAX_W-1:0] flit, input int unsigned width);
      return |((flit >> (width - 1)) & MAX_W'(1));
   endfunction

   function automatic logic [MAX_A-1:0] flit_addr(input logic [MAX_W-1:0] flit,
                                                  input int unsigned lsb,
                                                  input int unsigned aw);
      return MAX_A'((flit >> lsb) & MAX_W'((MAX_A'(1) << aw) - MAX_A'(1)));
   endfunction

   function automatic route_t route_port(input logic [MAX_A-1:0] addr,
                                         input logic [MAX_A-1:0] address,
                                         input logic [MAX_A-1:0] mask,
                                         input int unsigned      loc_w,
                                         input int unsigned      num_out,
                                         input logic             leaf);
      route_t r;
      r.drop = 1'b0;
      r.port = MAX_P'(addr & ((MAX_A'(1) << loc_w) - MAX_A'(1)));
      if (((addr ^ address) & mask) != '0) begin
         if (leaf) begin
            r.drop = 1'b1;
            r.port = '0;
         end else begin
            r.port = MAX_P'(num_out);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Circular-buffer FIFO with registered storage; an empty FIFO keeps presenting the last popped word.
module noc_sync_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [W-1:0]  push_data_i,
   input  logic          pop_i,
   output logic          full_o,
   output logic          empty_o,
   output logic [W-1:0]  data_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  last_q;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = empty_o ? last_q : mem_q[rd_q];

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= push_data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         last_q <= '0;
      end else begin
         if (do_push) wr_q <= nxt(wr_q);
         if (do_pop) begin
            rd_q   <= nxt(rd_q);
            last_q <= mem_q[rd_q];
         end
         if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
         else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/noc_decoder_nway.sv
// Wormhole decoder: routes each packet to a local port or the uplink, emits one select token per routed packet.
module noc_decoder_nway
   import noc_decoder_pkg::*;
#(
   parameter int unsigned       WIDTH    = 9,
   parameter int unsigned       ADDR_LSB = 4,
   parameter int unsigned       ADDR_W   = 4,
   parameter logic [ADDR_W-1:0] ADDRESS  = 4'b0000,
   parameter logic [ADDR_W-1:0] MASK     = 4'b1000,
   parameter int unsigned       NUM_OUT  = 2,
   parameter bit                LEAF     = 1'b1,
   parameter int unsigned       DEPTH    = 2,
   localparam int unsigned      NP       = NUM_OUT + 1,
   localparam int unsigned      SEL_W    = $clog2(NP),
   localparam int unsigned      LOC_W    = $clog2(NUM_OUT)
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic [NP-1:0]         out_valid,
   input  logic [NP-1:0]         out_ready,
   output logic [NP*WIDTH-1:0]   out_data,
   output logic                  sel_valid,
   input  logic                  sel_ready,
   output logic [SEL_W-1:0]      sel_data,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   state_e                  state_q, state_d;
   logic [SEL_W-1:0]        route_q, route_d, tgt;
   logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic [NP-1:0]           full, empty, push;
   logic                    sel_full, sel_empty, sel_push, tail, tgt_full;
   logic [CW-1:0]           count_unused [NP];
   logic [CW-1:0]           sel_count_unused;
   route_t                  hdr;

   assign tail     = flit_tail(MAX_W'(in_data), WIDTH);
   assign hdr      = route_port(flit_addr(MAX_W'(in_data), ADDR_LSB, ADDR_W),
                                MAX_A'(ADDRESS), MAX_A'(MASK), LOC_W, NUM_OUT, LEAF);
   assign tgt      = (state_q == HEAD) ? hdr.port[SEL_W-1:0] : route_q;
   assign tgt_full = |(full & (NP'(1) << tgt));
   assign drop_cnt = drop_cnt_q;

   always_comb begin
      in_ready   = 1'b1;
      state_d    = state_q;
      route_d    = route_q;
      drop_cnt_d = drop_cnt_q;
      sel_push   = 1'b0;
      push       = '0;
      assert (hdr.port < MAX_P'(NP));

      // Only headers wait on the select FIFO; body flits depend on their own port alone.
      case (state_q)
         HEAD:    if (!hdr.drop) in_ready = !tgt_full && !sel_full;
         BODY:    in_ready = !tgt_full;
         default: in_ready = 1'b1;
      endcase

      if (in_valid && in_ready) begin
         case (state_q)
            HEAD: begin
               route_d = tgt;
               if (hdr.drop) begin
                  if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
                  if (!tail) state_d = DROP;
               end else begin
                  sel_push = 1'b1;
                  push     = NP'(1) << tgt;
                  if (!tail) state_d = BODY;
               end
            end
            BODY: begin
               push = NP'(1) << route_q;
               if (tail) state_d = HEAD;
            end
            default: if (tail) state_d = HEAD;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= HEAD;
         route_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         route_q    <= route_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   for (genvar p = 0; p < NP; p++) begin : g_out
      noc_sync_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_fifo (
         .clk_i       (CLK),
         .rst_i       (RESET),
         .push_i      (push[p]),
         .push_data_i (in_data),
         .pop_i       (out_ready[p]),
         .full_o      (full[p]),
         .empty_o     (empty[p]),
         .data_o      (out_data[p*WIDTH +: WIDTH]),
         .count_o     (count_unused[p])
      );
      assign out_valid[p] = !empty[p];
   end

   noc_sync_fifo #(.W(SEL_W), .DEPTH(DEPTH)) u_sel_fifo (
      .clk_i       (CLK),
      .rst_i       (RESET),
      .push_i      (sel_push),
      .push_data_i (tgt),
      .pop_i       (sel_ready),
      .full_o      (sel_full),
      .empty_o     (sel_empty),
      .data_o      (sel_data),
      .count_o     (sel_count_unused)
   );
   assign sel_valid = !sel_empty;

endmodule

// File: tb/tb_noc_decoder_nway.sv
// Bench for noc_decoder_nway: table-driven packets with a per-port scoreboard plus stall/reset sequences.
module tb_noc_decoder_nway;

   localparam int NP = 3;
   localparam int W  = 9;

   logic            CLK = 1'b0;
   logic            RESET;
   logic            in_valid, in_ready;
   logic [W-1:0]    in_data;
   logic [NP-1:0]   out_valid, out_ready;
   logic [NP*W-1:0] out_data;
   logic            sel_valid, sel_ready;
   logic [1:0]      sel_data;
   logic [15:0]     drop_cnt;

   logic            in_valid2, in_ready2;
   logic [NP-1:0]   out_valid2, out_ready2;
   logic [NP*W-1:0] out_data2;
   logic            sel_valid2, sel_ready2;
   logic [1:0]      sel_data2;
   logic [15:0]     drop_cnt2;

   int checks = 0;
   int errors = 0;
   int exp_drops = 0;

   logic [W-1:0] expq [NP][$];
   logic [1:0]   selq [$];

   typedef struct {
      logic [W-1:0] flit;
      int           port;
      bit           head;
      bit           drop;
   } vec_t;

   vec_t vecs [8];

   always #5 CLK = ~CLK;

   noc_decoder_nway dut (
      .CLK(CLK), .RESET(RESET),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_data(sel_data),
      .drop_cnt(drop_cnt)
   );

   noc_decoder_nway #(.LEAF(1'b0)) dut_up (
      .CLK(CLK), .RESET(RESET),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
      .sel_valid(sel_valid2), .sel_ready(sel_ready2), .sel_data(sel_data2),
      .drop_cnt(drop_cnt2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_flit(input logic [W-1:0] f, input int port, input bit head, input bit drop);
      bit ok;
      ok = 1'b0;
      in_data  = f;
      in_valid = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge CLK);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout got in_ready=0 expected accept of flit %0h", f);
      end else if (drop) begin
         if (head) exp_drops++;
      end else begin
         expq[port].push_back(f);
         if (head) selq.push_back(port[1:0]);
      end
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic stall_check(input string nm, input logic [W-1:0] f);
      in_data  = f;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         chk(nm, 32'(in_ready), 32'd0);
      end
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
   endtask

   // Scoreboard: every transfer seen on a port must match the oldest expectation for that port.
   always @(negedge CLK) begin
      if (!RESET) begin
         for (int p = 0; p < NP; p++) begin
            if (out_valid[p] && out_ready[p]) begin
               if (expq[p].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL port%0d_unexpected got %0h expected nothing", p, out_data[p*W +: W]);
               end else begin
                  chk($sformatf("port%0d_data", p), 32'(out_data[p*W +: W]), 32'(expq[p].pop_front()));
               end
            end
         end
         if (sel_valid && sel_ready) begin
            if (selq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sel_unexpected got %0h expected nothing", sel_data);
            end else begin
               chk("sel_data", 32'(sel_data), 32'(selq.pop_front()));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{9'h020, 0, 1'b1, 1'b0};
      vecs[1] = '{9'h0AB, 0, 1'b0, 1'b0};
      vecs[2] = '{9'h1CD, 0, 1'b0, 1'b0};
      vecs[3] = '{9'h185, 0, 1'b1, 1'b1};
      vecs[4] = '{9'h085, 0, 1'b1, 1'b1};
      vecs[5] = '{9'h035, 0, 1'b0, 1'b1};
      vecs[6] = '{9'h100, 0, 1'b0, 1'b1};
      vecs[7] = '{9'h112, 1, 1'b1, 1'b0};

      RESET = 1'b1;
      in_valid = 1'b0;
      in_valid2 = 1'b0;
      in_data = '0;
      out_ready = '1;
      out_ready2 = '1;
      sel_ready = 1'b1;
      sel_ready2 = 1'b1;
      repeat (2) @(negedge CLK);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sel_valid", 32'(sel_valid), 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      @(posedge CLK);
      #1;
      RESET = 1'b0;

      // Single-flit packet: visible exactly one cycle after acceptance.
      send_flit(9'h135, 1, 1'b1, 1'b0);
      chk("t1_out_valid", 32'(out_valid), 32'b010);
      chk("t1_out_data", 32'(out_data[17:9]), 32'h135);
      chk("t1_sel_valid", 32'(sel_valid), 32'd1);
      chk("t1_sel_data", 32'(sel_data), 32'd1);
      chk("t1_drop_cnt", 32'(drop_cnt), 32'd0);

      for (int i = 0; i < 8; i++)
         send_flit(vecs[i].flit, vecs[i].port, vecs[i].head, vecs[i].drop);
      repeat (3) @(posedge CLK);
      #1;
      chk("table_drop_cnt", 32'(drop_cnt), 32'(exp_drops));

      // Miss on the non-leaf instance goes to the uplink.
      in_data = 9'h185;
      in_valid2 = 1'b1;
      @(negedge CLK);
      chk("up_in_ready", 32'(in_ready2), 32'd1);
      @(posedge CLK);
      #1;
      in_valid2 = 1'b0;
      chk("up_out_valid", 32'(out_valid2), 32'b100);
      chk("up_out_data", 32'(out_data2[26:18]), 32'h185);
      chk("up_sel_valid", 32'(sel_valid2), 32'd1);
      chk("up_sel_data", 32'(sel_data2), 32'd2);
      chk("up_drop_cnt", 32'(drop_cnt2), 32'd0);

      // Port 0 backpressured: it fills, port 1 still flows, then port 0 drains in order.
      out_ready[0] = 1'b0;
      send_flit(9'h100, 0, 1'b1, 1'b0);
      send_flit(9'h120, 0, 1'b1, 1'b0);
      stall_check("t4_port0_full_stall", 9'h140);
      send_flit(9'h131, 1, 1'b1, 1'b0);
      out_ready[0] = 1'b1;
      send_flit(9'h140, 0, 1'b1, 1'b0);
      send_flit(9'h160, 0, 1'b1, 1'b0);
      repeat (3) @(posedge CLK);
      #1;

      // Select FIFO full: body flits of the open packet pass, the next header waits.
      sel_ready = 1'b0;
      send_flit(9'h135, 1, 1'b1, 1'b0);
      send_flit(9'h020, 0, 1'b1, 1'b0);
      send_flit(9'h0AB, 0, 1'b0, 1'b0);
      send_flit(9'h1CD, 0, 1'b0, 1'b0);
      stall_check("t5_sel_full_stall", 9'h112);
      chk("t5_sel_front", 32'(sel_data), 32'd1);
      sel_ready = 1'b1;
      send_flit(9'h112, 1, 1'b1, 1'b0);
      repeat (4) @(posedge CLK);
      #1;
      chk("t5_drop_cnt", 32'(drop_cnt), 32'(exp_drops));

      // Reset right after a header opens a packet.
      send_flit(9'h020, 0, 1'b1, 1'b0);
      RESET = 1'b1;
      #1;
      chk("t6_out_valid", 32'(out_valid), 32'd0);
      chk("t6_sel_valid", 32'(sel_valid), 32'd0);
      chk("t6_drop_cnt", 32'(drop_cnt), 32'd0);
      for (int p = 0; p < NP; p++) expq[p].delete();
      selq.delete();
      exp_drops = 0;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      send_flit(9'h135, 1, 1'b1, 1'b0);
      chk("t6_hdr_out_valid", 32'(out_valid), 32'b010);
      chk("t6_hdr_sel_data", 32'(sel_data), 32'd1);

      repeat (10) @(posedge CLK);
      #1;
      for (int p = 0; p < NP; p++)
         chk($sformatf("port%0d_drained", p), 32'(expq[p].size()), 32'd0);
      chk("sel_drained", 32'(selq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
